// File: rtl/lin_comb_seq_pkg.sv
// lin_comb_pkg: shared definitions for the lin_comb_seq shift-and-add unit.
//   state_e : control FSM states (IDLE, MUL_X, MUL_Y, DONE)
//   res_w() : result width derived from operand and coefficient widths.
//             The extra bit is headroom for the a*x + b*y sum.
package lin_comb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL_X = 2'd1,
    MUL_Y = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic int res_w(input int data_w, input int coef_w);
    return data_w + coef_w + 1;
  endfunction

endpackage

// File: rtl/lin_comb_seq_if.sv
// lin_comb_seq_if: request/response bundle for lin_comb_seq.
//   start, sub, x, y, a, b : request side (driven by the master)
//   result, busy, done     : response side (driven by the unit)
// The master modport is used by whoever issues operations.
// The slave modport is used by the unit itself.
interface lin_comb_seq_if
  import lin_comb_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int COEF_W = 4
);
  localparam int RES_W = res_w(DATA_W, COEF_W);

  logic              start;
  logic              sub;
  logic [DATA_W-1:0] x;
  logic [DATA_W-1:0] y;
  logic [COEF_W-1:0] a;
  logic [COEF_W-1:0] b;
  logic [RES_W-1:0]  result;
  logic              busy;
  logic              done;

  modport master (
    output start, sub, x, y, a, b,
    input  result, busy, done
  );

  modport slave (
    input  start, sub, x, y, a, b,
    output result, busy, done
  );

endinterface

// File: rtl/lin_comb_seq_shift_add_lane.sv
// shift_add_lane: one shift-and-add multiplier lane.
// It is time-shared by lin_comb_seq, first for a*x and then for b*y.
//   clock, reset : clock and asynchronous active-high reset
//   load         : capture opnd_in (zero-extended) and coef_in
//   step         : shift the operand copy left and the coefficient copy right
//   sub          : present the current term negated (two's complement)
//   opnd_in      : operand to load
//   coef_in      : coefficient to load
//   term         : contribution of this cycle; 0 when the coefficient LSB is 0
//   last         : the remaining coefficient has no bits above the LSB, so
//                  this cycle is the final one for the current product
module shift_add_lane
  import lin_comb_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int COEF_W = 4
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  load,
  input  logic                                  step,
  input  logic                                  sub,
  input  logic [DATA_W-1:0]                     opnd_in,
  input  logic [COEF_W-1:0]                     coef_in,
  output logic [res_w(DATA_W, COEF_W)-1:0]      term,
  output logic                                  last
);
  localparam int RES_W = res_w(DATA_W, COEF_W);

  logic [RES_W-1:0]  opnd_q, opnd_d;
  logic [COEF_W-1:0] coef_q, coef_d;

  always_comb begin
    opnd_d = opnd_q;
    coef_d = coef_q;
    if (load) begin
      opnd_d = RES_W'(opnd_in);
      coef_d = coef_in;
    end else if (step) begin
      opnd_d = opnd_q << 1;
      coef_d = coef_q >> 1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      opnd_q <= '0;
      coef_q <= '0;
    end else begin
      opnd_q <= opnd_d;
      coef_q <= coef_d;
    end
  end

  // Subtraction folds into the accumulator adder by negating the term here.
  always_comb begin
    term = '0;
    if (coef_q[0]) begin
      term = sub ? (~opnd_q + RES_W'(1)) : opnd_q;
    end
  end

  assign last = ((coef_q >> 1) == '0);

endmodule

// File: rtl/lin_comb_seq.sv
// lin_comb_seq: sequential linear-combination unit.
// It computes result = a*x + b*y, or a*x - b*y when sub=1, modulo 2^RES_W.
//   clock : rising-edge clock
//   reset : asynchronous active-high reset; aborts any running operation
//   bus   : lin_comb_seq_if.slave carrying start/sub/x/y/a/b in and
//           result/busy/done out
// A single shift_add_lane handles a*x during MUL_X.
// It is then reloaded with the latched y and b for MUL_Y.
// Each multiply phase ends as soon as no higher coefficient bits remain, so
// its length is the coefficient's bit length, with a minimum of one cycle.
module lin_comb_seq
  import lin_comb_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int COEF_W = 4
) (
  input  logic           clock,
  input  logic           reset,
  lin_comb_seq_if.slave  bus
);
  localparam int RES_W = res_w(DATA_W, COEF_W);

  state_e            state_q, state_d;
  logic [RES_W-1:0]  acc_q, acc_d;
  logic [RES_W-1:0]  result_q, result_d;
  logic [DATA_W-1:0] y_q, y_d;
  logic [COEF_W-1:0] b_q, b_d;
  logic              sub_q, sub_d;

  logic              lane_load;
  logic              lane_step;
  logic              lane_sub;
  logic [DATA_W-1:0] lane_opnd;
  logic [COEF_W-1:0] lane_coef;
  logic [RES_W-1:0]  lane_term;
  logic              lane_last;

  shift_add_lane #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W)
  ) u_lane (
    .clock   (clock),
    .reset   (reset),
    .load    (lane_load),
    .step    (lane_step),
    .sub     (lane_sub),
    .opnd_in (lane_opnd),
    .coef_in (lane_coef),
    .term    (lane_term),
    .last    (lane_last)
  );

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    result_d  = result_q;
    y_d       = y_q;
    b_d       = b_q;
    sub_d     = sub_q;
    lane_load = 1'b0;
    lane_step = 1'b0;
    lane_sub  = 1'b0;
    lane_opnd = bus.x;
    lane_coef = bus.a;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          // x and a go straight into the lane.
          // y, b and sub are held here until the second phase.
          y_d       = bus.y;
          b_d       = bus.b;
          sub_d     = bus.sub;
          acc_d     = '0;
          lane_load = 1'b1;
          state_d   = MUL_X;
        end
      end

      MUL_X: begin
        acc_d = acc_q + lane_term;
        if (lane_last) begin
          // Reload the lane with the second product's operands.
          lane_load = 1'b1;
          lane_opnd = y_q;
          lane_coef = b_q;
          state_d   = MUL_Y;
        end else begin
          lane_step = 1'b1;
        end
      end

      MUL_Y: begin
        lane_sub = sub_q;
        acc_d    = acc_q + lane_term;
        if (lane_last) begin
          result_d = acc_q + lane_term;
          state_d  = DONE;
        end else begin
          lane_step = 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      result_q <= '0;
      y_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      y_q      <= y_d;
      b_q      <= b_d;
      sub_q    <= sub_d;
    end
  end

  assign bus.result = result_q;
  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = (state_q == DONE);

endmodule
